// File: rtl/fan_ramp_ctrl_pkg.sv
// Shared speed codes, ramp state encodings and default duty levels
// for the fan drive path.
package fan_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    SPD_HIGH = 2'b00,
    SPD_MED  = 2'b01,
    SPD_LOW  = 2'b10,
    SPD_OFF  = 2'b11
  } speed_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_KICK      = 2'd3
  } ramp_state_e;

  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_STEP_DIV   = 1000;
  localparam int DEF_RAMP_STEP  = 5;
  localparam int DEF_DUTY_HIGH  = 255;
  localparam int DEF_DUTY_MED   = 170;
  localparam int DEF_DUTY_LOW   = 85;
  localparam int DEF_KICK_STEPS = 8;

endpackage

// File: rtl/fan_ramp_ctrl_pwm.sv
// PWM carrier for the fan driver: period 2^PWM_BITS-1, so an
// all-ones duty is a constant high and zero a constant low.
module fan_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  localparam logic [PWM_BITS-1:0] CNT_TOP = ~PWM_BITS'(1);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + PWM_BITS'(1);
    pwm_d = (cnt_q < duty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Soft start/stop of the fan duty toward the speed-code target.
// FAN_KICKSTART_EN adds a full-duty kick before spinning up from rest.
module fan_ramp_ctrl
  import fan_ramp_ctrl_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int STEP_DIV   = DEF_STEP_DIV,
  parameter int RAMP_STEP  = DEF_RAMP_STEP,
  parameter int DUTY_HIGH  = DEF_DUTY_HIGH,
  parameter int DUTY_MED   = DEF_DUTY_MED,
  parameter int DUTY_LOW   = DEF_DUTY_LOW,
  parameter int KICK_STEPS = DEF_KICK_STEPS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          speed,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy,
  output logic                at_target
);

  localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int SUM_W = PWM_BITS + 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(STEP_DIV - 1);
  localparam logic [SUM_W-1:0] STEP_W  = SUM_W'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] T_HIGH = PWM_BITS'(DUTY_HIGH);
  localparam logic [PWM_BITS-1:0] T_MED  = PWM_BITS'(DUTY_MED);
  localparam logic [PWM_BITS-1:0] T_LOW  = PWM_BITS'(DUTY_LOW);

`ifdef FAN_KICKSTART_EN
  localparam int KW = (KICK_STEPS > 1) ? $clog2(KICK_STEPS) : 1;
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_STEPS - 1);
  localparam logic [PWM_BITS-1:0] D_MAX = '1;
  logic [KW-1:0] kick_q, kick_d;
`endif

  ramp_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                busy_q, busy_d;
  logic                at_q, at_d;

  logic [PWM_BITS-1:0] tgt;
  logic [SUM_W-1:0]    sum;
  logic [PWM_BITS-1:0] gap;
  logic [PWM_BITS-1:0] up_val;
  logic [PWM_BITS-1:0] dn_val;
  logic                tick;

  always_comb begin
    tgt = '0;
    unique case (1'b1)
      (speed == SPD_HIGH): tgt = T_HIGH;
      (speed == SPD_MED):  tgt = T_MED;
      (speed == SPD_LOW):  tgt = T_LOW;
      default:             tgt = '0;
    endcase
  end

  assign tick = (state_q != ST_IDLE) && (pre_q == PRE_TOP);

  // Wide sum and gap compare keep both ramp directions clamped.
  always_comb begin
    sum    = {1'b0, duty_q} + STEP_W;
    gap    = duty_q - tgt;
    up_val = (sum >= {1'b0, tgt}) ? tgt : sum[PWM_BITS-1:0];
    dn_val = ({1'b0, gap} <= STEP_W) ? tgt
           : duty_q - STEP_W[PWM_BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pre_d   = '0;
`ifdef FAN_KICKSTART_EN
    kick_d  = kick_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef FAN_KICKSTART_EN
        if (duty_q == '0 && tgt != '0) begin
          state_d = ST_KICK;
          duty_d  = D_MAX;
          kick_d  = '0;
        end else
`endif
        if (tgt > duty_q) state_d = ST_RAMP_UP;
        else if (tgt < duty_q) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_UP, ST_RAMP_DOWN: begin
`ifdef FAN_KICKSTART_EN
        if (duty_q == '0 && tgt != '0) begin
          state_d = ST_KICK;
          duty_d  = D_MAX;
          kick_d  = '0;
        end else
`endif
        if (duty_q == tgt) begin
          state_d = ST_IDLE;
        end else if (tgt > duty_q) begin
          state_d = ST_RAMP_UP;
          if (tick) duty_d = up_val;
        end else begin
          state_d = ST_RAMP_DOWN;
          if (tick) duty_d = dn_val;
        end
      end
      ST_KICK: begin
`ifdef FAN_KICKSTART_EN
        duty_d = D_MAX;
        if (tgt == '0) begin
          state_d = ST_RAMP_DOWN;
        end else if (tick) begin
          if (kick_q == KICK_LAST) state_d = ST_RAMP_DOWN;
          else kick_d = kick_q + KW'(1);
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // Prescaler runs only while ramping; direction flips keep its phase.
    if (state_q != ST_IDLE && state_d != ST_IDLE)
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    busy_d = (state_d != ST_IDLE);
    at_d   = (duty_q == tgt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      at_q    <= 1'b1;
`ifdef FAN_KICKSTART_EN
      kick_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      at_q    <= at_d;
`ifdef FAN_KICKSTART_EN
      kick_q  <= kick_d;
`endif
    end
  end

  fan_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .duty (duty_q),
    .pwm  (pwm)
  );

  assign duty      = duty_q;
  assign busy      = busy_q;
  assign at_target = at_q;

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// Scoreboard bench for fan_ramp_ctrl: expected duty steps are queued
// with their clock-edge stamps and checked by an independent monitor.
module tb_fan_ramp_ctrl;
  import fan_ramp_ctrl_pkg::*;

  localparam int PB = 8;
  localparam int SD = 4;
  localparam int RS = 7;
  localparam int KS = 8;
  localparam int DH = 255;
  localparam int DM = 170;
  localparam int DL = 85;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    speed = SPD_OFF;
  logic          pwm;
  logic [PB-1:0] duty;
  logic          busy;
  logic          at_target;

  fan_ramp_ctrl #(
    .PWM_BITS(PB), .STEP_DIV(SD), .RAMP_STEP(RS),
    .DUTY_HIGH(DH), .DUTY_MED(DM), .DUTY_LOW(DL),
    .KICK_STEPS(KS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .speed(speed), .pwm(pwm),
    .duty(duty), .busy(busy), .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct { int dv; int ev; } exp_t;
  exp_t sbq[$];
  int   pv[$];
  exp_t mx;

  int ecnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  int m_duty = 0;
  int hold_d = 0;
  int base_e, kdone, end_e;
  bit end_at0, kicked;
  logic [1:0] rs, rs2;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               nm, act, exp, ecnt);
    end
  endtask

  function automatic int tgt_of(input logic [1:0] s);
    case (s)
      2'b00:   return DH;
      2'b01:   return DM;
      2'b10:   return DL;
      default: return 0;
    endcase
  endfunction

  // Monitor: a queued step must appear on its edge, otherwise hold.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      hold_d = 0;
    end else begin
      while (sbq.size() > 0 && sbq[0].ev < ecnt) begin
        mx = sbq.pop_front();
        chk("duty_missed", 32'hFFFF_FFFF, mx.dv);
      end
      if (sbq.size() > 0 && sbq[0].ev == ecnt) begin
        mx = sbq.pop_front();
        chk("duty_step", duty, mx.dv);
        hold_d = mx.dv;
      end else begin
        chk("duty_hold", duty, hold_d);
      end
    end
  end

  task automatic push_plan(input int start, input int tgt, input int k0);
    int d = start;
    int k = k0;
    exp_t x;
    pv.delete();
    while (d != tgt) begin
      k++;
      if (tgt > d) d = (d + RS > tgt) ? tgt : d + RS;
      else d = (d - RS < tgt) ? tgt : d - RS;
      x.dv = d;
      x.ev = base_e + SD * k;
      sbq.push_back(x);
      pv.push_back(d);
    end
    kdone  = k;
    m_duty = tgt;
  endtask

  task automatic apply_idle(input logic [1:0] s);
    int t;
    exp_t x;
    t       = tgt_of(s);
    speed   = s;
    base_e  = ecnt + 1;
    end_at0 = 1'b1;
    kicked  = 1'b0;
    kdone   = 0;
    if (t == m_duty) begin
      end_e = -1;
    end
`ifdef FAN_KICKSTART_EN
    else if (m_duty == 0) begin
      kicked = 1'b1;
      x.dv = (1 << PB) - 1;
      x.ev = base_e;
      sbq.push_back(x);
      push_plan(x.dv, t, KS);
      if (t == x.dv) begin
        end_e   = base_e + SD * KS;
        end_at0 = 1'b0;
      end else begin
        end_e = base_e + SD * kdone;
      end
    end
`endif
    else begin
      push_plan(m_duty, t, 0);
      end_e = base_e + SD * kdone;
    end
  endtask

  task automatic start(input logic [1:0] s);
    apply_idle(s);
    @(negedge clk);
    if (end_e >= 0) chk("busy_rise", busy, 1);
  endtask

  task automatic mid_change(input int j, input logic [1:0] s);
    int t, cur;
    while (ecnt < base_e + SD * j) @(negedge clk);
    cur     = pv[j-1];
    t       = tgt_of(s);
    speed   = s;
    sbq.delete();
    m_duty  = cur;
    end_at0 = 1'b1;
    if (t == cur) begin
      end_e = ecnt;
    end else begin
      push_plan(cur, t, j);
      end_e = base_e + SD * kdone;
    end
  endtask

  task automatic wait_end();
    if (end_e < 0) begin
      repeat (2) @(negedge clk);
    end else begin
      while (ecnt < end_e) @(negedge clk);
      chk("busy_before_done", busy, 1);
      if (end_at0) chk("at_target_before_done", at_target, 0);
      @(negedge clk);
    end
    chk("busy_done", busy, 0);
    chk("at_target_done", at_target, 1);
    chk("duty_done", duty, m_duty);
  endtask

  task automatic pwm_check(input string nm);
    int c = 0;
    repeat (255) begin
      @(negedge clk);
      if (pwm === 1'b1) c++;
    end
    chk(nm, c, m_duty);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_at_target", at_target, 1);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("off_busy", busy, 0);
    chk("off_at_target", at_target, 1);
    pwm_check("off_pwm_high");

    start(SPD_LOW);
    wait_end();
    pwm_check("low_pwm_high");

    start(SPD_HIGH);
    mid_change(9, SPD_OFF);
    wait_end();
    pwm_check("off_after_high_pwm_high");

    start(SPD_MED);
    wait_end();
    pwm_check("med_pwm_high");

    start(SPD_OFF);
    wait_end();
    start(SPD_HIGH);
    while (ecnt < base_e + SD * 6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_duty", duty, 0);
    chk("async_rst_pwm", pwm, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_at_target", at_target, 1);
    sbq.delete();
    m_duty = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start(SPD_HIGH);
    wait_end();
    pwm_check("high_pwm_high");

    for (int it = 0; it < 16; it++) begin
      rs  = 2'($urandom_range(0, 3));
      rs2 = 2'($urandom_range(0, 3));
      start(rs);
      if (!kicked && kdone >= 2 && $urandom_range(0, 1) == 1)
        mid_change(int'($urandom_range(1, kdone - 1)), rs2);
      wait_end();
      if (it % 4 == 0) pwm_check("rand_pwm_high");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
